// File: rtl/peripheral_dpfifo.sv
// peripheral_dpfifo: bus-mapped FIFO (DATA/STATUS/CTRL/LEVEL) over a simple dual-port RAM.
// Define PERIPHERAL_DPFIFO_IRQ_EN to build the level-threshold interrupt and THR register.
module peripheral_dpfifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_in,
  input  logic              cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] d_out,
  output logic              irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0] count;
  logic ovf, udf, empty, full;
  logic rd_data, wr_data, push, pop, ctrl_wr, flush, clr;
  logic [DATA_W-1:0] status, ctrl, rdata;
  logic unused_addr;
  assign unused_addr = ^addr[ADDR_W-1:2];
  assign empty   = count == '0;
  assign full    = count == MAX;
  assign rd_data = cs && rd && addr[1:0] == 2'd0;
  assign wr_data = cs && wr && addr[1:0] == 2'd0;
  assign pop     = rd_data && !empty;
  // a full FIFO still accepts a push when the same cycle pops
  assign push    = wr_data && (!full || pop);
  assign ctrl_wr = cs && wr && addr[1:0] == 2'd2;
  assign flush   = ctrl_wr && d_in[0];
  assign clr     = ctrl_wr && d_in[1];
  assign status  = DATA_W'({udf, ovf, irq, full, empty});
`ifdef PERIPHERAL_DPFIFO_IRQ_EN
  localparam logic [DEPTH_LOG2-1:0] THR_RST = {1'b1, {(DEPTH_LOG2-1){1'b0}}};
  logic [DEPTH_LOG2-1:0] thr;
  assign ctrl = DATA_W'({thr, 2'b00});
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thr <= THR_RST;
      irq <= 1'b0;
    end else begin
      if (ctrl_wr) thr <= d_in[DEPTH_LOG2+1:2];
      irq <= thr != '0 && count >= {1'b0, thr};
    end
  end
`else
  assign ctrl = '0;
  assign irq  = 1'b0;
`endif
  assign rdata = addr[1:0] == 2'd0 ? (empty ? '0 : mem[rptr]) :
                 addr[1:0] == 2'd1 ? status :
                 addr[1:0] == 2'd2 ? ctrl : DATA_W'(count);
  // storage has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= d_in;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
      d_out <= '0;
    end else begin
      if (cs && rd) d_out <= rdata;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        count <= count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
      end
      if (clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (wr_data && !push) ovf <= 1'b1;
        if (rd_data && empty) udf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_peripheral_dpfifo.sv
// tb_peripheral_dpfifo: directed vector table plus irq and async-reset sequences, DEPTH_LOG2=2.
module tb_peripheral_dpfifo;
`ifdef PERIPHERAL_DPFIFO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [15:0] I = IRQ ? 16'h4 : 16'h0;
  typedef struct {
    logic        c;
    logic [1:0]  a;
    logic        r;
    logic        w;
    logic [15:0] d;
    logic        chk;
    logic [15:0] exp;
  } vec_t;
  vec_t tv[$];
  logic clk = 0, reset = 0, cs = 0, rd = 0, wr = 0;
  logic [15:0] d_in = 0, addr = 0, d_out;
  logic irq;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  peripheral_dpfifo #(.DATA_W(16), .DEPTH_LOG2(2), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out), .irq(irq)
  );
  function automatic void add(logic c, logic [1:0] a, logic r, logic w, logic [15:0] d,
                              logic chk, logic [15:0] exp);
    tv.push_back('{c, a, r, w, d, chk, exp});
  endfunction
  task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic step(input logic c, input logic [15:0] a, input logic r, input logic w,
                      input logic [15:0] d);
    cs = c; addr = a; rd = r; wr = w; d_in = d;
    @(posedge clk);
    #1;
    cs = 0; rd = 0; wr = 0;
  endtask
  initial begin
    add(1, 2, 1, 0, 0, 1, IRQ ? 16'h8 : 16'h0);
    add(1, 0, 0, 1, 16'h1111, 0, 0);
    add(1, 0, 0, 1, 16'h2222, 0, 0);
    add(1, 0, 0, 1, 16'h3333, 0, 0);
    add(1, 3, 1, 0, 0, 1, 16'd3);
    add(1, 0, 1, 0, 0, 1, 16'h1111);
    add(1, 0, 1, 0, 0, 1, 16'h2222);
    add(1, 0, 1, 0, 0, 1, 16'h3333);
    add(1, 1, 1, 0, 0, 1, 16'h1);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 1, 16'hA0 + 16'(k), 0, 0);
    add(1, 1, 1, 0, 0, 1, 16'h2 | I);
    add(1, 0, 0, 1, 16'hA4, 0, 0);
    add(1, 1, 1, 0, 0, 1, 16'hA | I);
    add(1, 3, 1, 0, 0, 1, 16'd4);
    for (int k = 0; k < 4; k++) add(1, 0, 1, 0, 0, 1, 16'hA0 + 16'(k));
    add(1, 1, 1, 0, 0, 1, 16'h9);
    add(1, 0, 1, 0, 0, 1, 16'h0);
    add(1, 1, 1, 0, 0, 1, 16'h19);
    add(1, 2, 0, 1, 16'hA, 0, 0);
    add(1, 1, 1, 0, 0, 1, 16'h1);
    add(1, 0, 0, 1, 16'hB0, 0, 0);
    add(1, 0, 0, 1, 16'hB1, 0, 0);
    add(1, 0, 1, 1, 16'hB2, 1, 16'hB0);
    add(1, 3, 1, 0, 0, 1, 16'd2);
    add(1, 0, 1, 0, 0, 1, 16'hB1);
    add(1, 0, 1, 0, 0, 1, 16'hB2);
    add(1, 1, 1, 0, 0, 1, 16'h1);
    add(1, 0, 1, 1, 16'hC0, 1, 16'h0);
    add(1, 3, 1, 0, 0, 1, 16'd1);
    add(1, 0, 1, 0, 0, 1, 16'hC0);
    add(1, 1, 1, 0, 0, 1, 16'h11);
    add(1, 2, 0, 1, 16'hA, 0, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 1, 16'hD0 + 16'(k), 0, 0);
    add(1, 0, 1, 1, 16'hD4, 1, 16'hD0);
    add(1, 1, 1, 0, 0, 1, 16'h2 | I);
    add(1, 3, 1, 0, 0, 1, 16'd4);
    for (int k = 1; k < 5; k++) add(1, 0, 1, 0, 0, 1, 16'hD0 + 16'(k));
    add(0, 0, 0, 0, 0, 1, 16'hD4);
    add(0, 0, 1, 0, 0, 1, 16'hD4);
    add(0, 0, 0, 1, 16'hEE, 1, 16'hD4);
    add(1, 3, 1, 0, 0, 1, 16'd0);
    add(1, 1, 1, 0, 0, 1, 16'h1);
    #3;
    check("reset_dout", d_out, 16'h0);
    check("reset_irq", {15'b0, irq}, 16'h0);
    @(posedge clk);
    #1 reset = 1;
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].c, {14'(i * 37), tv[i].a}, tv[i].r, tv[i].w, tv[i].d);
      if (tv[i].chk) check($sformatf("vec%0d", i), d_out, tv[i].exp);
    end
    step(1, 16'h2, 0, 1, 16'hC);
    for (int k = 0; k < 3; k++) step(1, 16'h0, 0, 1, 16'h50 + 16'(k));
    check("irq_after_push3", {15'b0, irq}, 16'h0);
    step(0, 16'h0, 0, 0, 0);
    check("irq_rise", {15'b0, irq}, {15'b0, IRQ});
    step(1, 16'h0, 1, 0, 0);
    check("irq_pop_data", d_out, 16'h50);
    check("irq_pop_edge", {15'b0, irq}, {15'b0, IRQ});
    step(0, 16'h0, 0, 0, 0);
    check("irq_fall", {15'b0, irq}, 16'h0);
    step(1, 16'h2, 0, 1, 16'hD);
    step(1, 16'h3, 1, 0, 0);
    check("flush_level", d_out, 16'h0);
    step(1, 16'h2, 1, 0, 0);
    check("flush_thr", d_out, IRQ ? 16'hC : 16'h0);
    for (int k = 0; k < 3; k++) step(1, 16'h0, 0, 1, 16'h60 + 16'(k));
    step(1, 16'h3, 1, 0, 0);
    check("burst_level", d_out, 16'd3);
    check("burst_irq", {15'b0, irq}, {15'b0, IRQ});
    #2 reset = 0;
    #1;
    check("async_rst_dout", d_out, 16'h0);
    check("async_rst_irq", {15'b0, irq}, 16'h0);
    @(posedge clk);
    #1;
    check("rst_hold_dout", d_out, 16'h0);
    reset = 1;
    step(1, 16'h1, 1, 0, 0);
    check("post_rst_status", d_out, 16'h1);
    step(1, 16'h3, 1, 0, 0);
    check("post_rst_level", d_out, 16'h0);
    step(1, 16'h2, 1, 0, 0);
    check("post_rst_thr", d_out, IRQ ? 16'h8 : 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/peripheral_dpfifo.md
PERIPHERAL_DPFIFO -- requirements
Module: peripheral_dpfifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width of bus and storage.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, giving a FIFO depth of 2**DEPTH_LOG2 words (legal range 2..12).
REQ-003 SHALL have parameter ADDR_W, default 16, bus address width; only addr[1:0] is decoded.
REQ-004 SHALL have the following ports, one per line:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_in  in  DATA_W  bus write data.
- cs  in  1  peripheral select; rd and wr are ignored when low.
- addr  in  ADDR_W  register select.
- rd  in  1  bus read strobe.
- wr  in  1  bus write strobe.
- d_out  out  DATA_W  registered bus read data.
- irq  out  1  level-threshold interrupt.

Function
REQ-005 SHALL decode the register map on addr[1:0]: 0 DATA, 1 STATUS, 2 CTRL, 3 LEVEL.
REQ-006 SHALL push d_in into the FIFO on a cycle where cs=1, wr=1, addr=DATA and not full.
REQ-007 SHALL pop the head word on a cycle where cs=1, rd=1, addr=DATA and not empty, and present it on d_out on the next cycle (1-cycle read latency).
REQ-008 SHALL present all register reads on d_out one cycle after the strobe; d_out SHALL hold its value when no read is issued.
REQ-009 SHALL return STATUS as {zero-fill, underflow, overflow, irq, full, empty} in bits [4:0].
REQ-010 SHALL return LEVEL as the current word count (0..2**DEPTH_LOG2), zero-extended to DATA_W.
REQ-011 SHALL treat a CTRL write as follows: bit0=1 flushes pointers and count; bit1=1 clears both sticky flags; bits[DEPTH_LOG2+1:2] load the irq threshold THR.
REQ-012 SHALL return CTRL on read with THR in bits[DEPTH_LOG2+1:2] and bits 1:0 reading 0.
REQ-013 SHALL maintain write/read pointers of DEPTH_LOG2 bits that wrap from 2**DEPTH_LOG2-1 to 0, and a count of DEPTH_LOG2+1 bits.
REQ-014 SHALL assert empty when count=0 and full when count=2**DEPTH_LOG2, both combinational from the count register.
REQ-015 SHALL drop a push when full, leave the contents unchanged, and set the sticky overflow flag.
REQ-016 SHALL perform no pop on a read when empty, return 0 on d_out, and set the sticky underflow flag.
REQ-017 SHALL, when rd and wr are both high on DATA in one cycle with 0<count<max, perform both push and pop and leave count unchanged; when empty only the push occurs; when full both occur.
REQ-018 SHALL give a CTRL flush priority over any sticky set in the same cycle; a flush SHALL NOT alter THR.
REQ-019 SHALL store data in a simple dual-port array (write port on push, read port on pop) that synthesises to block RAM.

Reset
REQ-020 SHALL, while reset=0, force pointers, count, sticky flags, d_out and irq to 0 and THR to 2**(DEPTH_LOG2-1), regardless of clk.
REQ-021 SHALL discard FIFO contents on reset mid-operation; the array itself need not be cleared.

Configuration
REQ-022 SHALL provide the macro PERIPHERAL_DPFIFO_IRQ_EN.
REQ-023 SHALL, when the macro is defined, register irq high the cycle after count>=THR and THR!=0, and low the cycle after count<THR.
REQ-024 SHALL, when the macro is undefined, tie irq to 0, read STATUS bit2 as 0, and omit the THR register (CTRL bits[DEPTH_LOG2+1:2] write-ignored, read 0).

Verification
REQ-025 Reset, then write 0x1111, 0x2222, 0x3333 to DATA -> LEVEL=3, and three DATA reads return 0x1111, 0x2222, 0x3333 each one cycle after rd, then STATUS.empty=1.
REQ-026 DEPTH_LOG2=2: push 5 words 0xA0..0xA4 -> full=1 after the 4th, overflow=1, and pops return 0xA0..0xA3.
REQ-027 Read DATA when empty -> d_out=0, underflow=1; write CTRL=0x2 -> both sticky flags read 0.
REQ-028 With count=2, simultaneous rd+wr on DATA -> count stays 2, head word out, new word at tail; with count=0, the same cycle -> count=1.
REQ-029 With IRQ_EN, THR=4: push 4 words -> irq=1 one cycle after the 4th push; pop 1 -> irq=0; CTRL flush -> LEVEL=0 and THR still 4.
REQ-030 Assert reset=0 asynchronously mid-burst with count=3 -> d_out, LEVEL, flags and irq read 0 immediately; after release, empty=1.
